// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the register-file write path.
//   AW        register address width (register 0 is hardwired zero)
//   DW        register data width
//   REG_ZERO  address of the hardwired zero register
//   wb_req_t  one register-file write request {rw, da, d}, as produced by
//             the pipeline write-back stage and by this arbiter's output mux
package risc_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] da;
        logic [DW-1:0] d;
    } wb_req_t;

endpackage

// File: rtl/risc_wb_hold_fifo.sv
// risc_wb_hold_fifo: small in-order holding FIFO for multi-cycle unit results.
// Ports:
//   clk, reset          clock, synchronous active-high reset (control only)
//   push, push_da/_d    store one {da, d} entry at the tail
//   pop                 retire the head entry
//   head_da, head_d     current head entry (meaningful while count != 0)
//   count               number of stored entries (0..DEPTH)
//   entry_vld, entry_da per-slot valid bits and destinations, for hazard compare
// The caller never pushes while full nor pops while empty.
module risc_wb_hold_fifo
    import risc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [AW-1:0]              push_da,
    input  logic [DW-1:0]              push_d,
    input  logic                       pop,
    output logic [AW-1:0]              head_da,
    output logic [DW-1:0]              head_d,
    output logic [CW-1:0]              count,
    output logic [DEPTH-1:0]           entry_vld,
    output logic [DEPTH-1:0][AW-1:0]   entry_da
);

    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q,  count_d;
    logic [DEPTH-1:0]           vld_q,    vld_d;
    logic [DEPTH-1:0][AW-1:0]   mem_da_q, mem_da_d;
    logic [DEPTH-1:0][DW-1:0]   mem_d_q,  mem_d_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        mem_da_d = mem_da_q;
        mem_d_d  = mem_d_q;

        // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end

        // Push after pop: the two only share a slot when the FIFO is empty,
        // which pop never is, so the order only matters for readability.
        if (push) begin
            vld_d[wr_ptr_q]    = 1'b1;
            mem_da_d[wr_ptr_q] = push_da;
            mem_d_d[wr_ptr_q]  = push_d;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        mem_da_q <= mem_da_d;
        mem_d_q  <= mem_d_d;
    end

    assign head_da   = mem_da_q[rd_ptr_q];
    assign head_d    = mem_d_q[rd_ptr_q];
    assign count     = count_q;
    assign entry_vld = vld_q;
    assign entry_da  = mem_da_q;

endmodule

// File: rtl/risc_wb_port_arbiter.sv
// risc_wb_port_arbiter: shares the register file's single write port between
// the pipeline write-back stage and buffered multi-cycle unit (MCU) results.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   pipe_rw, pipe_da, pipe_d         pipeline write-back request
//   pipe_stall                       pipeline write refused; WB holds it
//   mcu_valid, mcu_da, mcu_d         MCU result offer
//   mcu_ready                        holding FIFO can take a result
//   dof_aa, dof_ba                   DOF operand addresses
//   hazard_a, hazard_b               operand matches a buffered MCU destination
//   wb_rw, wb_da, wb_d               register-file write port
// All outputs are combinational from inputs and registered state. The
// wb_req_t fields follow the package widths, so AW/DW are expected to match.
module risc_wb_port_arbiter
    import risc_pkg::*;
#(
    parameter int DW           = risc_pkg::DW,
    parameter int AW           = risc_pkg::AW,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_rw,
    input  logic [AW-1:0] pipe_da,
    input  logic [DW-1:0] pipe_d,
    output logic          pipe_stall,
    input  logic          mcu_valid,
    input  logic [AW-1:0] mcu_da,
    input  logic [DW-1:0] mcu_d,
    output logic          mcu_ready,
    input  logic [AW-1:0] dof_aa,
    input  logic [AW-1:0] dof_ba,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic          wb_rw,
    output logic [AW-1:0] wb_da,
    output logic [DW-1:0] wb_d
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int AGW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [AGW-1:0] LIMIT_C = AGW'(STARVE_LIMIT);

    logic                     pipe_req;
    logic                     nonempty;
    logic                     grant_mcu;
    logic                     mcu_push;
    logic                     fifo_store;
    logic [AW-1:0]            head_da;
    logic [DW-1:0]            head_d;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         entry_vld;
    logic [DEPTH-1:0][AW-1:0] entry_da;
    logic [AGW-1:0]           age_q, age_d;
    logic                     hit_a, hit_b;
    wb_req_t                  sel;

    // Everything visible is forced quiet while reset is asserted; gating the
    // request terms here keeps every output at zero without a separate mux.
    assign pipe_req  = !reset && pipe_rw && (pipe_da != '0);
    assign nonempty  = (count != '0);
    assign mcu_ready = !reset && (count < DEPTH_C);
    assign grant_mcu = !reset && nonempty && (!pipe_req || (age_q >= LIMIT_C));
    assign pipe_stall = pipe_req && grant_mcu;

    // Results for R0 are acknowledged to the MCU but never stored.
    assign mcu_push   = mcu_valid && mcu_ready;
    assign fifo_store = mcu_push && (mcu_da != '0);

    risc_wb_hold_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_hold_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_store),
        .push_da   (mcu_da),
        .push_d    (mcu_d),
        .pop       (grant_mcu),
        .head_da   (head_da),
        .head_d    (head_d),
        .count     (count),
        .entry_vld (entry_vld),
        .entry_da  (entry_da)
    );

    // Head-of-queue wait counter; saturates so it cannot wrap back below
    // the limit while the pipeline keeps the port busy.
    always_comb begin
        age_d = age_q;
        if (grant_mcu) begin
            age_d = '0;
        end else if (nonempty) begin
            age_d = (age_q >= LIMIT_C) ? LIMIT_C : age_q + 1'b1;
        end else begin
            age_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        sel    = '0;
        sel.da = REG_ZERO;
        if (grant_mcu) begin
            sel.rw = 1'b1;
            sel.da = head_da;
            sel.d  = head_d;
        end else if (pipe_req) begin
            sel.rw = 1'b1;
            sel.da = pipe_da;
            sel.d  = pipe_d;
        end
    end

    assign wb_rw = sel.rw;
    assign wb_da = sel.da;
    assign wb_d  = sel.d;

    // Compares stored entries only: a result being pushed this cycle is not
    // visible yet, while the head being popped still flags until it is gone.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_da[i] == dof_aa)) hit_a = 1'b1;
            if (entry_vld[i] && (entry_da[i] == dof_ba)) hit_b = 1'b1;
        end
    end

    assign hazard_a = !reset && (dof_aa != '0) && hit_a;
    assign hazard_b = !reset && (dof_ba != '0) && hit_b;

endmodule

// File: tb/tb_risc_wb_port_arbiter.sv
module tb_risc_wb_port_arbiter;
    import risc_pkg::*;

    localparam int TDW = 32;
    localparam int TAW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           pipe_rw;
    logic [TAW-1:0] pipe_da;
    logic [TDW-1:0] pipe_d;
    logic           pipe_stall;
    logic           mcu_valid;
    logic [TAW-1:0] mcu_da;
    logic [TDW-1:0] mcu_d;
    logic           mcu_ready;
    logic [TAW-1:0] dof_aa;
    logic [TAW-1:0] dof_ba;
    logic           hazard_a;
    logic           hazard_b;
    logic           wb_rw;
    logic [TAW-1:0] wb_da;
    logic [TDW-1:0] wb_d;

    int checks = 0;
    int errors = 0;

    // Expected register-file writes, pushed when the stimulus is driven.
    wb_req_t exp_q[$];
    wb_req_t e;

    risc_wb_port_arbiter #(
        .DW(TDW), .AW(TAW), .DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_rw(pipe_rw), .pipe_da(pipe_da), .pipe_d(pipe_d), .pipe_stall(pipe_stall),
        .mcu_valid(mcu_valid), .mcu_da(mcu_da), .mcu_d(mcu_d), .mcu_ready(mcu_ready),
        .dof_aa(dof_aa), .dof_ba(dof_ba), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wb_rw(wb_rw), .wb_da(wb_da), .wb_d(wb_d)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_rw = 0; pipe_da = '0; pipe_d = '0;
        mcu_valid = 0; mcu_da = '0; mcu_d = '0;
        dof_aa = '0; dof_ba = '0;
    endtask

    task automatic test_reset();
        reset = 1; pipe_rw = 1; pipe_da = 7; pipe_d = 32'hDEAD_BEEF;
        mcu_valid = 1; mcu_da = 5; mcu_d = 32'h55; dof_aa = 5; dof_ba = 7;
        next();
        @(negedge clk);
        checks++;
        if ({pipe_stall, mcu_ready, hazard_a, hazard_b, wb_rw} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/ready/ha/hb/rw=%b want 00000",
                     {pipe_stall, mcu_ready, hazard_a, hazard_b, wb_rw});
        end
        checks++;
        if ({wb_da, wb_d} !== '0) begin
            errors++; $display("FAIL reset_data: got da=%0d d=%h want 0 0", wb_da, wb_d);
        end
        next();
        reset = 0; idle_inputs(); dof_aa = 5;
        @(negedge clk);
        checks++;
        if ({mcu_ready, wb_rw, hazard_a} !== 3'b100) begin
            errors++; $display("FAIL post_reset: got ready/rw/ha=%b want 100",
                               {mcu_ready, wb_rw, hazard_a});
        end
        next();
        idle_inputs();
    endtask

    task automatic test_pipe_only();
        pipe_rw = 1; pipe_da = 7; pipe_d = 32'hA5A5_A5A5;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back('{rw: 1'b1, da: 5'd7, d: 32'hA5A5_A5A5});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({wb_rw, wb_da, wb_d, pipe_stall} !== {e.rw, e.da, e.d, 1'b0}) begin
                errors++;
                $display("FAIL pipe_only_%0d: got rw=%0b da=%0d d=%h stall=%0b want rw=1 da=%0d d=%h stall=0",
                         c, wb_rw, wb_da, wb_d, pipe_stall, e.da, e.d);
            end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_mcu_idle();
        mcu_valid = 1; mcu_da = 9; mcu_d = 32'h1234; dof_aa = 9;
        exp_q.push_back('{rw: 1'b1, da: 5'd9, d: 32'h1234});
        @(negedge clk);
        checks++;
        if ({mcu_ready, wb_rw, hazard_a} !== 3'b100) begin
            errors++; $display("FAIL mcu_idle_push: got ready/rw/ha=%b want 100",
                               {mcu_ready, wb_rw, hazard_a});
        end
        next();
        mcu_valid = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({wb_rw, wb_da, wb_d, hazard_a} !== {e.rw, e.da, e.d, 1'b1}) begin
            errors++;
            $display("FAIL mcu_idle_write: got rw=%0b da=%0d d=%h ha=%0b want rw=1 da=%0d d=%h ha=1",
                     wb_rw, wb_da, wb_d, hazard_a, e.da, e.d);
        end
        next();
        @(negedge clk);
        checks++;
        if ({wb_rw, hazard_a} !== 2'b00) begin
            errors++; $display("FAIL mcu_idle_after: got rw/ha=%b want 00", {wb_rw, hazard_a});
        end
        next();
        idle_inputs();
    endtask

    task automatic test_starvation();
        pipe_rw = 1; pipe_da = 7; pipe_d = 32'h11;
        mcu_valid = 1; mcu_da = 3; mcu_d = 32'h33; dof_ba = 3;
        exp_q.push_back('{rw: 1'b1, da: 5'd3, d: 32'h33});
        @(negedge clk);
        checks++;
        if ({wb_rw, wb_da, pipe_stall, hazard_b} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL starve_push: got rw=%0b da=%0d stall=%0b hb=%0b want 1 7 0 0",
                               wb_rw, wb_da, pipe_stall, hazard_b);
        end
        next();
        mcu_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({wb_rw, wb_da, wb_d, pipe_stall, hazard_b} !== {1'b1, 5'd7, 32'h11, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL starve_wait_%0d: got rw=%0b da=%0d d=%h stall=%0b hb=%0b want 1 7 11 0 1",
                         c, wb_rw, wb_da, wb_d, pipe_stall, hazard_b);
            end
            next();
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({wb_rw, wb_da, wb_d, pipe_stall} !== {e.rw, e.da, e.d, 1'b1}) begin
            errors++;
            $display("FAIL starve_grant: got rw=%0b da=%0d d=%h stall=%0b want rw=1 da=%0d d=%h stall=1",
                     wb_rw, wb_da, wb_d, pipe_stall, e.da, e.d);
        end
        next();
        @(negedge clk);
        checks++;
        if ({wb_rw, wb_da, pipe_stall, hazard_b} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL starve_resume: got rw=%0b da=%0d stall=%0b hb=%0b want 1 7 0 0",
                               wb_rw, wb_da, pipe_stall, hazard_b);
        end
        next();
        idle_inputs();
    endtask

    task automatic test_full();
        pipe_rw = 1; pipe_da = 7; pipe_d = 32'h77;
        mcu_valid = 1; mcu_da = 10; mcu_d = 32'hA;
        exp_q.push_back('{rw: 1'b1, da: 5'd10, d: 32'hA});
        next();                                    // c0 -> c1
        mcu_da = 11; mcu_d = 32'hB;
        exp_q.push_back('{rw: 1'b1, da: 5'd11, d: 32'hB});
        next();                                    // c1 -> c2
        mcu_da = 12; mcu_d = 32'hC; dof_aa = 11;
        exp_q.push_back('{rw: 1'b1, da: 5'd12, d: 32'hC});
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({mcu_ready, wb_da, pipe_stall, hazard_a} !== {1'b0, 5'd7, 1'b0, 1'b1}) begin
                errors++; $display("FAIL full_hold_c%0d: got ready=%0b da=%0d stall=%0b ha=%0b want 0 7 0 1",
                                   c, mcu_ready, wb_da, pipe_stall, hazard_a);
            end
            next();
        end
        @(negedge clk);                            // c5: forced stall, first pop
        e = exp_q.pop_front();
        checks++;
        if ({mcu_ready, pipe_stall, wb_rw, wb_da, wb_d} !== {1'b0, 1'b1, e.rw, e.da, e.d}) begin
            errors++; $display("FAIL full_pop1: got ready=%0b stall=%0b rw=%0b da=%0d d=%h want 0 1 1 %0d %h",
                               mcu_ready, pipe_stall, wb_rw, wb_da, wb_d, e.da, e.d);
        end
        next();
        @(negedge clk);                            // c6: held result accepted
        checks++;
        if ({mcu_ready, wb_da, pipe_stall} !== {1'b1, 5'd7, 1'b0}) begin
            errors++; $display("FAIL full_accept: got ready=%0b da=%0d stall=%0b want 1 7 0",
                               mcu_ready, wb_da, pipe_stall);
        end
        next();
        mcu_valid = 0; pipe_rw = 0;
        for (int c = 7; c <= 8; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL full_drain_c%0d: got write da=%0d want none queued", c, wb_da);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({wb_rw, wb_da, wb_d} !== {e.rw, e.da, e.d}) begin
                    errors++; $display("FAIL full_drain_c%0d: got rw=%0b da=%0d d=%h want 1 %0d %h",
                                       c, wb_rw, wb_da, wb_d, e.da, e.d);
                end
            end
            next();
        end
        @(negedge clk);
        checks++;
        if ({wb_rw, mcu_ready} !== 2'b01) begin
            errors++; $display("FAIL full_empty: got rw/ready=%b want 01", {wb_rw, mcu_ready});
        end
        next();
        idle_inputs();
    endtask

    task automatic test_r0();
        pipe_rw = 1; pipe_da = 0; pipe_d = 32'hFF;
        @(negedge clk);
        checks++;
        if ({wb_rw, pipe_stall} !== 2'b00) begin
            errors++; $display("FAIL r0_pipe: got rw/stall=%b want 00", {wb_rw, pipe_stall});
        end
        next();
        pipe_rw = 0; mcu_valid = 1; mcu_da = 0; mcu_d = 32'h77; dof_aa = 0;
        @(negedge clk);
        checks++;
        if (mcu_ready !== 1'b1) begin
            errors++; $display("FAIL r0_mcu_ready: got %0b want 1", mcu_ready);
        end
        next();
        mcu_valid = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({wb_rw, hazard_a, mcu_ready} !== 3'b001) begin
                errors++; $display("FAIL r0_mcu_drop_%0d: got rw/ha/ready=%b want 001",
                                   c, {wb_rw, hazard_a, mcu_ready});
            end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        pipe_rw = 1; pipe_da = 7; pipe_d = 32'h1;
        mcu_valid = 1; mcu_da = 20; mcu_d = 32'h20;
        next();
        mcu_da = 21; mcu_d = 32'h21;
        next();
        mcu_valid = 0; dof_aa = 20; dof_ba = 21; reset = 1;
        @(negedge clk);
        checks++;
        if ({wb_rw, wb_da, wb_d, pipe_stall, mcu_ready, hazard_a, hazard_b} !== '0) begin
            errors++; $display("FAIL reset_mid_hold: got rw=%0b da=%0d d=%h stall=%0b ready=%0b ha=%0b hb=%0b want all 0",
                               wb_rw, wb_da, wb_d, pipe_stall, mcu_ready, hazard_a, hazard_b);
        end
        next();
        reset = 0; pipe_rw = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({wb_rw, mcu_ready, hazard_a, hazard_b} !== 4'b0100) begin
                errors++; $display("FAIL reset_mid_after_%0d: got rw/ready/ha/hb=%b want 0100",
                                   c, {wb_rw, mcu_ready, hazard_a, hazard_b});
            end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 5; c++) begin
            if (c < 4) begin
                mcu_valid = 1; mcu_da = 5'(c + 1); mcu_d = 32'h1111 * (c + 1);
                exp_q.push_back('{rw: 1'b1, da: 5'(c + 1), d: 32'h1111 * (c + 1)});
            end else begin
                mcu_valid = 0;
            end
            @(negedge clk);
            checks++;
            if (mcu_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", c, mcu_ready);
            end
            if (c >= 1 && c <= 4) begin
                e = exp_q.pop_front();
                checks++;
                if ({wb_rw, wb_da, wb_d} !== {e.rw, e.da, e.d}) begin
                    errors++; $display("FAIL b2b_write_%0d: got rw=%0b da=%0d d=%h want 1 %0d %h",
                                       c, wb_rw, wb_da, wb_d, e.da, e.d);
                end
            end else if (c == 5) begin
                checks++;
                if (wb_rw !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle: got rw=%0b want 0", wb_rw);
                end
            end
            next();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        next();
        test_reset();
        test_pipe_only();
        test_mcu_idle();
        test_starvation();
        test_full();
        test_r0();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
